// File: rtl/multiplicacao_escalar_seq_if.sv
// multiplicacao_escalar_seq_if: start/done request and packed matrix bus for the scalar multiplier
interface multiplicacao_escalar_seq_if #(
  parameter int N = 5,
  parameter int W = 8
);
  logic             start;
  logic [N*N*W-1:0] matriz_A;
  logic [W-1:0]     num_inteiro;
  logic             modo_sat;
  logic [N*N*W-1:0] nova_matriz_A;
  logic             busy;
  logic             done;
  logic             overflow;
  modport master (
    output start, matriz_A, num_inteiro, modo_sat,
    input  nova_matriz_A, busy, done, overflow
  );
  modport slave (
    input  start, matriz_A, num_inteiro, modo_sat,
    output nova_matriz_A, busy, done, overflow
  );
endinterface

// File: rtl/multiplicacao_escalar_seq.sv
// multiplicacao_escalar_seq: sequential scalar x matrix multiplier, LANES elements per cycle, wrap/saturate
module multiplicacao_escalar_seq #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int LANES = 5
) (
  input logic                      clk,
  input logic                      rst_n,
  multiplicacao_escalar_seq_if.slave bus
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN + LANES + 1);
  localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [NN*W-1:0]  a_q, res_q, res_n, nova_q;
  logic [W-1:0]     s_q;
  logic             sat_q, acc_q, acc_n, ovf_q, busy_q, done_q;
  logic [IW-1:0]    idx;
  logic signed [2*W-1:0] p;
  logic [W-1:0]     r;
  logic             last;
  assign last = int'(idx) + LANES >= NN;
  // one cycle of lane arithmetic: lanes past the last element are skipped entirely
  always_comb begin
    res_n = res_q;
    acc_n = acc_q;
    p = '0;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(idx) + l < NN) begin
        p = (2*W)'($signed(a_q[(int'(idx)+l)*W +: W])) * (2*W)'($signed(s_q));
        r = (sat_q && p > PMAX) ? PMAX[W-1:0] : (sat_q && p < PMIN) ? PMIN[W-1:0] : p[W-1:0];
        acc_n = acc_n | (p > PMAX) | (p < PMIN);
        res_n[(int'(idx)+l)*W +: W] = r;
      end
    end
  end
  // control FSM: capture on start, sweep in CALC, publish results and pulse done from DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      s_q    <= '0;
      sat_q  <= 1'b0;
      idx    <= '0;
      res_q  <= '0;
      acc_q  <= 1'b0;
      nova_q <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_q    <= bus.matriz_A;
          s_q    <= bus.num_inteiro;
          sat_q  <= bus.modo_sat;
          idx    <= '0;
          res_q  <= '0;
          acc_q  <= 1'b0;
          busy_q <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          res_q <= res_n;
          acc_q <= acc_n;
          idx   <= idx + IW'(LANES);
          if (last) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          nova_q <= res_q;
          ovf_q  <= acc_q;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.nova_matriz_A = nova_q;
  assign bus.overflow      = ovf_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_multiplicacao_escalar_seq.sv
// tb_multiplicacao_escalar_seq: table vectors, random ops against an arithmetic model, handshake corner cases
module tb_multiplicacao_escalar_seq;
  localparam int N = 5, W = 8, NB = N*N*W;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  multiplicacao_escalar_seq_if #(.N(N), .W(W)) bus0 ();
  multiplicacao_escalar_seq_if #(.N(N), .W(W)) bus1 ();
  multiplicacao_escalar_seq #(.N(N), .W(W), .LANES(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multiplicacao_escalar_seq #(.N(N), .W(W), .LANES(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  typedef struct {
    int            d;
    logic [NB-1:0] a;
    logic [7:0]    s;
    logic          sat;
    logic [NB-1:0] e;
    logic          o;
  } vec_t;
  vec_t tv [7];
  int checks = 0, failures = 0;
  logic [NB-1:0] prev [2];
  task automatic chk(input string n, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input int d, input logic [NB-1:0] a, input logic [7:0] s, input logic sat, input logic st);
    if (d == 0) begin
      bus0.matriz_A = a; bus0.num_inteiro = s; bus0.modo_sat = sat; bus0.start = st;
    end else begin
      bus1.matriz_A = a; bus1.num_inteiro = s; bus1.modo_sat = sat; bus1.start = st;
    end
  endtask
  function automatic logic [NB-1:0] nova(input int d);
    return d == 0 ? bus0.nova_matriz_A : bus1.nova_matriz_A;
  endfunction
  function automatic logic bsy(input int d);
    return d == 0 ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic dn(input int d);
    return d == 0 ? bus0.done : bus1.done;
  endfunction
  function automatic logic ovf(input int d);
    return d == 0 ? bus0.overflow : bus1.overflow;
  endfunction
  function automatic void model(input logic [NB-1:0] a, input logic [7:0] s, input logic sat,
                                output logic [NB-1:0] r, output logic o);
    logic signed [7:0] ai, si;
    int p, v;
    r = '0;
    o = 1'b0;
    si = s;
    for (int k = 0; k < N*N; k++) begin
      ai = a[k*8 +: 8];
      p = ai * si;
      if (p > 127 || p < -128) o = 1'b1;
      v = !sat ? p : p > 127 ? 127 : p < -128 ? -128 : p;
      r[k*8 +: 8] = v[7:0];
    end
  endfunction
  task automatic run_op(input string n, input int d, input logic [NB-1:0] a, input logic [7:0] s,
                        input logic sat, input bit glitch, input logic [NB-1:0] er, input logic eo);
    int c, lat, bc, extra;
    bit hold_ok;
    c = d == 0 ? 5 : 7;
    lat = 0; bc = 0; extra = 0; hold_ok = 1'b1;
    @(negedge clk);
    drive(d, a, s, sat, 1'b1);
    for (int i = 1; i <= c + 4; i++) begin
      @(negedge clk);
      if (dn(d)) begin
        lat = i;
        break;
      end
      bc += int'(bsy(d));
      if (nova(d) !== prev[d]) hold_ok = 1'b0;
      if (glitch) drive(d, ~a, s + 8'd1, ~sat, 1'b1);
      else drive(d, a, s, sat, 1'b0);
    end
    drive(d, a, s, sat, 1'b0);
    chk({n, " latency"}, NB'(lat - 1), NB'(c + 1));
    chk({n, " busy cycles"}, NB'(bc), NB'(c));
    chk({n, " hold old result"}, NB'(hold_ok), NB'(1));
    chk({n, " busy in done cycle"}, NB'(bsy(d)), NB'(0));
    chk({n, " result"}, nova(d), er);
    chk({n, " overflow"}, NB'(ovf(d)), NB'(eo));
    @(negedge clk);
    chk({n, " done width"}, NB'(dn(d)), NB'(0));
    if (glitch) begin
      for (int i = 0; i < c + 3; i++) begin
        extra += int'(dn(d));
        @(negedge clk);
      end
      chk({n, " extra done"}, NB'(extra), NB'(0));
    end
    prev[d] = er;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [NB-1:0] ra, re;
    logic [7:0] rs;
    logic rsat, ro;
    int dones;
    prev[0] = '0;
    prev[1] = '0;
    foreach (tv[i]) begin
      tv[i].d = 0; tv[i].a = '0; tv[i].e = '0; tv[i].s = '0; tv[i].sat = 1'b0; tv[i].o = 1'b0;
    end
    for (int k = 0; k < N*N; k++) begin
      tv[0].a[k*8 +: 8] = 8'(k + 1);
      tv[0].e[k*8 +: 8] = 8'(3 * (k + 1));
      tv[1].a[k*8 +: 8] = 8'd1;
      tv[1].e[k*8 +: 8] = 8'd3;
      tv[6].a[k*8 +: 8] = 8'(k + 1);
      tv[6].e[k*8 +: 8] = 8'(2 * (k + 1));
    end
    tv[0].s = 8'd3;
    tv[1].a[7:0] = 8'd100; tv[1].s = 8'd3; tv[1].sat = 1'b1; tv[1].e[7:0] = 8'd127; tv[1].o = 1'b1;
    tv[2] = tv[1];
    tv[2].sat = 1'b0; tv[2].e[7:0] = 8'd44;
    tv[3].a[7:0] = 8'h80; tv[3].s = 8'hFF; tv[3].sat = 1'b1; tv[3].e[7:0] = 8'h7F; tv[3].o = 1'b1;
    tv[4] = tv[3];
    tv[4].sat = 1'b0; tv[4].e[7:0] = 8'h80;
    tv[5].a[7:0] = 8'hFE; tv[5].s = 8'd64; tv[5].sat = 1'b1; tv[5].e[7:0] = 8'h80;
    tv[6].d = 1; tv[6].s = 8'd2;
    drive(0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset result", nova(d), '0);
      chk("reset flags", NB'({bsy(d), dn(d), ovf(d)}), NB'(0));
    end
    rst_n = 1'b1;
    foreach (tv[i]) run_op($sformatf("vec%0d", i), tv[i].d, tv[i].a, tv[i].s, tv[i].sat, 1'b0, tv[i].e, tv[i].o);
    chk("lanes4 elem24", NB'(bus1.nova_matriz_A[24*8 +: 8]), NB'(50));
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < N*N; k++) ra[k*8 +: 8] = 8'($urandom);
      rs = it % 4 == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rsat = 1'($urandom);
      model(ra, rs, rsat, re, ro);
      run_op($sformatf("rand%0d", it), it % 2, ra, rs, rsat, 1'b0, re, ro);
    end
    run_op("glitch", 0, tv[0].a, tv[0].s, 1'b0, 1'b1, tv[0].e, 1'b0);
    @(negedge clk);
    drive(0, tv[1].a, tv[1].s, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, tv[1].a, tv[1].s, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy before abort", NB'(bsy(0)), NB'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", NB'(bsy(0)), NB'(0));
    chk("abort done/ovf", NB'({dn(0), ovf(0)}), NB'(0));
    chk("abort result", nova(0), '0);
    chk("abort other unit", nova(1), '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dones += int'(dn(0));
    end
    chk("no done after abort", NB'(dones), NB'(0));
    prev[0] = '0;
    prev[1] = '0;
    run_op("after abort", 0, tv[0].a, tv[0].s, 1'b0, 1'b0, tv[0].e, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
